// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one 8N1 UART transmit line among NREQ
//   byte requesters. A granted byte goes out as start bit, 8 data bits LSB
//   first, and a stop bit. Each bit is held for CLKS_PER_BIT clocks.
// Ports
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   req       : per-requester "byte ready", held until the matching ack
//   data_in   : byte of requester i on data_in[8*i +: 8]
//   ack       : one-cycle pulse, byte of requester i captured
//   grant_id  : requester whose frame is on tx (holds while idle)
//   busy      : high from the start bit through the stop bit
//   tx        : serial output, idles high
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int IDW          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data_in,
  output logic [NREQ-1:0]   ack,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            tx_q, tx_d;

  logic [IDW-1:0]  win;
  logic            found;
  logic            last_cyc;
  logic            arb;

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign last_cyc = (cnt_q == CW'(CLKS_PER_BIT - 1));
  // Arbitrating on the last stop cycle lets the next start bit follow with
  // no idle gap.
  assign arb = found && ((state_q == IDLE) || (state_q == STOP && last_cyc));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    ack_d   = '0;
    busy_d  = busy_q;
    tx_d    = tx_q;

    if (state_q != IDLE) cnt_d = last_cyc ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: ;
      START: begin
        if (last_cyc) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (last_cyc) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // tx is registered, so present the following bit one step early.
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (last_cyc) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb) begin
      state_d = START;
      cnt_d   = '0;
      shift_d = data_in[8*int'(win) +: 8];
      gid_d   = win;
      ack_d   = NREQ'(1) << win;
      ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a 4-requester/16-clock instance and a
// 2-requester/4-clock instance share one clock. The expected grant order comes
// from a round-robin pick over the request mask. Each frame is decoded by a
// behavioural receiver that samples mid-bit and also requires every bit
// window to be flat.
module tb_uart_tx_arbiter;
  localparam int NA = 4, CPB = 16, NB = 2, CPB_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] req_a, ack_a;
  logic [1:0] req_b, ack_b;
  logic [31:0] data_a;
  logic [15:0] data_b;
  logic [1:0] gid_a;
  logic [0:0] gid_b;
  logic       busy_a, busy_b, tx_a, tx_b;
  logic [7:0] byte_a [4];
  logic [7:0] byte_b [2];

  assign data_a = {byte_a[3], byte_a[2], byte_a[1], byte_a[0]};
  assign data_b = {byte_b[1], byte_b[0]};

  uart_tx_arbiter #(.NREQ(NA), .CLKS_PER_BIT(CPB), .IDW(2)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .data_in(data_a), .ack(ack_a),
    .grant_id(gid_a), .busy(busy_a), .tx(tx_a));

  uart_tx_arbiter #(.NREQ(NB), .CLKS_PER_BIT(CPB_B), .IDW(1)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .data_in(data_b), .ack(ack_b),
    .grant_id(gid_b), .busy(busy_b), .tx(tx_b));

  int npass = 0, ntot = 0;
  int ptr_a = 0, ptr_b = 0;

  function automatic int rr_pick(input int mask, input int ptr, input int n);
    for (int k = 0; k < n; k++) if (mask[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  // Waits (bounded) for the ack of a new frame and checks its first cycle.
  task automatic frame_head(input bit sel, input int exp_w, input int max_wait,
                            input string tag);
    int waited = 0;
    logic [7:0] ackv;
    ackv = sel ? 8'(ack_b) : 8'(ack_a);
    while (ackv == 8'd0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
      ackv = sel ? 8'(ack_b) : 8'(ack_a);
    end
    ntot++;
    if (ackv !== 8'(1 << exp_w)) $display("FAIL %s ack: got %0h want %0h", tag, ackv, 8'(1 << exp_w));
    else npass++;
    ntot++;
    if (waited != 0) $display("FAIL %s latency: got %0d want 0 extra cycles", tag, waited);
    else npass++;
    ntot++;
    if (int'(sel ? {1'b0, gid_b} : gid_a) != exp_w)
      $display("FAIL %s grant_id: got %0d want %0d", tag, sel ? {1'b0, gid_b} : gid_a, exp_w);
    else npass++;
    ntot++;
    if ((sel ? tx_b : tx_a) !== 1'b0 || (sel ? busy_b : busy_a) !== 1'b1)
      $display("FAIL %s start: got tx=%b busy=%b want tx=0 busy=1", tag,
               sel ? tx_b : tx_a, sel ? busy_b : busy_a);
    else npass++;
  endtask

  // Receives one whole frame starting at the current (start-bit) cycle and
  // ends on the last stop cycle.
  task automatic frame_tail(input bit sel, input logic [7:0] exp_byte, input string tag);
    int cpb;
    logic s [160];
    int acks = 0;
    bit busy_ok = 1'b1, fmt_ok = 1'b1;
    logic [7:0] rx;
    cpb = sel ? CPB_B : CPB;
    for (int c = 0; c < 10 * cpb; c++) begin
      if (c > 0) @(negedge clk);
      s[c] = sel ? tx_b : tx_a;
      if (sel ? (ack_b != 2'd0) : (ack_a != 4'd0)) acks++;
      if ((sel ? busy_b : busy_a) !== 1'b1) busy_ok = 1'b0;
    end
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < cpb; j++)
        if (s[b*cpb + j] !== s[b*cpb]) fmt_ok = 1'b0;
    if (s[0] !== 1'b0 || s[9*cpb] !== 1'b1) fmt_ok = 1'b0;
    for (int d = 0; d < 8; d++) rx[d] = s[(d + 1)*cpb + cpb/2];
    ntot++;
    if (rx !== exp_byte) $display("FAIL %s rx byte: got %h want %h", tag, rx, exp_byte);
    else npass++;
    ntot++;
    if (!fmt_ok) $display("FAIL %s frame format: got bad bit windows want 10 flat bits of %0d", tag, cpb);
    else npass++;
    ntot++;
    if (acks != 1) $display("FAIL %s ack pulses: got %0d want 1", tag, acks);
    else npass++;
    ntot++;
    if (!busy_ok) $display("FAIL %s busy: got low in frame want high", tag);
    else npass++;
  endtask

  task automatic check_idle(input bit sel, input string tag);
    ntot++;
    if ((sel ? tx_b : tx_a) !== 1'b1 || (sel ? busy_b : busy_a) !== 1'b0 ||
        (sel ? (ack_b !== 2'd0) : (ack_a !== 4'd0)))
      $display("FAIL %s idle: got tx=%b busy=%b want tx=1 busy=0 ack=0", tag,
               sel ? tx_b : tx_a, sel ? busy_b : busy_a);
    else npass++;
  endtask

  // Serves the current request mask for up to nframes frames using the
  // round-robin model. At each ack the winner may drop its request or
  // present a fresh byte. After the last frame all requests are released.
  task automatic run(input bit sel, input int nframes, input int drop_pct,
                     input bit rnd_data, input string tag);
    int n, mask, w;
    logic [7:0] eb;
    n = sel ? NB : NA;
    for (int f = 0; f < nframes; f++) begin
      mask = sel ? int'(req_b) : int'(req_a);
      if (mask == 0) break;
      if (sel) begin w = rr_pick(mask, ptr_b, n); ptr_b = (w + 1) % n; eb = byte_b[w]; end
      else     begin w = rr_pick(mask, ptr_a, n); ptr_a = (w + 1) % n; eb = byte_a[w]; end
      frame_head(sel, w, (f == 0) ? 1 : 0, tag);
      if (f == nframes - 1) begin
        req_a = sel ? req_a : 4'd0;
        req_b = sel ? 2'd0 : req_b;
      end else if (int'($urandom_range(99)) < drop_pct) begin
        if (sel) req_b[w] = 1'b0; else req_a[w] = 1'b0;
      end else if (rnd_data) begin
        if (sel) byte_b[w] = 8'($urandom); else byte_a[w] = 8'($urandom);
      end
      frame_tail(sel, eb, tag);
      @(negedge clk);
    end
    check_idle(sel, tag);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; req_a = '0; req_b = '0;
    for (int i = 0; i < 4; i++) byte_a[i] = '0;
    byte_b[0] = '0; byte_b[1] = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    ptr_a = 0; ptr_b = 0;
    ntot++;
    if (gid_a !== 2'd0) $display("FAIL reset grant_id: got %0d want 0", gid_a);
    else npass++;
    check_idle(1'b0, "reset_a");
    check_idle(1'b1, "reset_b");
  endtask

  task automatic test_back_to_back();
    byte_a[0] = 8'h11; byte_a[1] = 8'h22; byte_a[2] = 8'h33; byte_a[3] = 8'h44;
    req_a = 4'b1111;
    @(negedge clk);
    run(1'b0, 5, 0, 1'b0, "back_to_back");
  endtask

  task automatic test_single();
    byte_a[0] = 8'hA5;
    req_a = 4'b0001;
    @(negedge clk);
    frame_head(1'b0, 0, 1, "single");
    req_a = 4'b0000;
    frame_tail(1'b0, 8'hA5, "single");
    @(negedge clk);
    check_idle(1'b0, "single");
    ptr_a = 1;
  endtask

  task automatic test_rr_resume();
    logic [7:0] b2, b0, b2n;
    b2 = 8'($urandom); b0 = 8'($urandom); b2n = 8'($urandom);
    byte_a[2] = b2;
    req_a = 4'b0100;
    @(negedge clk);
    frame_head(1'b0, 2, 1, "rr_first");
    req_a = 4'b0101; byte_a[0] = b0; byte_a[2] = b2n;
    frame_tail(1'b0, b2, "rr_first");
    @(negedge clk);
    frame_head(1'b0, 0, 0, "rr_resume0");
    req_a = 4'b0100;
    frame_tail(1'b0, b0, "rr_resume0");
    @(negedge clk);
    frame_head(1'b0, 2, 0, "rr_resume2");
    req_a = 4'b0000;
    frame_tail(1'b0, b2n, "rr_resume2");
    @(negedge clk);
    check_idle(1'b0, "rr_resume");
    ptr_a = 3;
  endtask

  task automatic test_withdrawn();
    logic [7:0] b3;
    int st, len, stray;
    b3 = 8'($urandom); byte_a[3] = b3; byte_a[1] = 8'($urandom);
    st = int'($urandom_range(80, 5)); len = int'($urandom_range(60, 1));
    req_a = 4'b1000;
    @(negedge clk);
    frame_head(1'b0, 3, 1, "withdrawn");
    req_a = 4'b0000;
    fork
      frame_tail(1'b0, b3, "withdrawn");
      begin
        repeat (st) @(negedge clk);
        req_a[1] = 1'b1;
        repeat (len) @(negedge clk);
        req_a[1] = 1'b0;
      end
    join
    @(negedge clk);
    check_idle(1'b0, "withdrawn");
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack_a !== 4'd0 || tx_a !== 1'b1) stray++;
    end
    ntot++;
    if (stray != 0) $display("FAIL withdrawn stray activity: got %0d cycles want 0", stray);
    else npass++;
    ptr_a = 0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b, b0, b1;
    b = 8'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
    byte_a[0] = b;
    req_a = 4'b0001;
    @(negedge clk);
    frame_head(1'b0, 0, 1, "reset_mid");
    req_a = 4'b0000;
    repeat (4*CPB + 5) @(negedge clk);
    ntot++;
    if (tx_a !== b[3]) $display("FAIL reset_mid data bit3: got %b want %b", tx_a, b[3]);
    else npass++;
    rst_a = 1'b1;
    @(negedge clk);
    check_idle(1'b0, "reset_mid");
    ntot++;
    if (gid_a !== 2'd0) $display("FAIL reset_mid grant_id: got %0d want 0", gid_a);
    else npass++;
    rst_a = 1'b0;
    byte_a[0] = b0; byte_a[1] = b1;
    req_a = 4'b0011;
    @(negedge clk);
    frame_head(1'b0, 0, 1, "after_reset0");
    req_a = 4'b0010;
    frame_tail(1'b0, b0, "after_reset0");
    @(negedge clk);
    frame_head(1'b0, 1, 0, "after_reset1");
    req_a = 4'b0000;
    frame_tail(1'b0, b1, "after_reset1");
    @(negedge clk);
    check_idle(1'b0, "after_reset");
    ptr_a = 2;
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) byte_a[i] = 8'($urandom);
      req_a = 4'($urandom_range(15, 1));
      @(negedge clk);
      run(1'b0, int'($urandom_range(7, 2)), 40, 1'b1, "random");
    end
  endtask

  task automatic test_sweep();
    byte_b[0] = 8'($urandom); byte_b[1] = 8'($urandom);
    req_b = 2'b11;
    @(negedge clk);
    run(1'b1, 6, 0, 1'b1, "sweep");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_rr_resume();
    test_withdrawn();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
